// File: rtl/aes_bist_pkg.sv
// aes_bist_pkg: shared types, golden AES-128 vectors and ROM lookup for the AES BIST sequencer
package aes_bist_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RST_DUT, S_WAIT, S_CHECK, S_DONE} state_t;
  localparam int DATA_W_DEF = 128;
  typedef struct packed {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;
  localparam vec_t VEC0 = '{
    pt:  128'h00112233445566778899aabbccddeeff,
    key: 128'h000102030405060708090a0b0c0d0e0f,
    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a
  };
  localparam vec_t VEC1 = '{
    pt:  128'h3243f6a8885a308d313198a2e0370734,
    key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
    ct:  128'h3925841d02dc09fbdc118597196a0b32
  };
  // Only two golden vectors exist; higher indices replicate them alternately.
  function automatic vec_t vec_at(input int i);
    return (i % 2 == 1) ? VEC1 : VEC0;
  endfunction
endpackage

// File: rtl/aes_bist_vec_rom.sv
// aes_bist_vec_rom: combinational vector index to plaintext/key/ciphertext lookup
//   idx : vector index (width $clog2(NUM_VEC), min 1)
//   vec : golden record for that index
module aes_bist_vec_rom
  import aes_bist_pkg::*;
#(
  parameter int NUM_VEC = 2,
  localparam int IW = NUM_VEC > 1 ? $clog2(NUM_VEC) : 1
) (
  input  logic [IW-1:0] idx,
  output vec_t          vec
);
  assign vec = vec_at(32'(idx));
endmodule

// File: rtl/aes_bist_sequencer.sv
// aes_bist_sequencer: multi-vector built-in self-test driver/checker for the AES_top core
//   clk, rst (async, active-high), start       : clock, reset, run request
//   dut_rst, plaintext, key / dut_out           : stimulus to and response from AES_top
//   busy, done, pass, fail_count, first_fail_idx: run status and results
//   fail_capture (only with AES_BIST_CAPTURE_EN): dut_out ^ golden ct of the first failing vector
module aes_bist_sequencer
  import aes_bist_pkg::*;
#(
  parameter int NUM_VEC = 2,
  parameter int LATENCY = 40,
  parameter int RST_CYC = 2,
  parameter int DATA_W  = DATA_W_DEF,
  localparam int IW   = NUM_VEC > 1 ? $clog2(NUM_VEC) : 1,
  localparam int FW   = $clog2(NUM_VEC + 1),
  localparam int MAXC = LATENCY > RST_CYC ? LATENCY : RST_CYC,
  localparam int CW   = $clog2(MAXC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              dut_rst,
  output logic [DATA_W-1:0] plaintext,
  output logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FW-1:0]     fail_count,
`ifdef AES_BIST_CAPTURE_EN
  output logic [DATA_W-1:0] fail_capture,
`endif
  output logic [IW-1:0]     first_fail_idx
);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_W-1:0] exp_ct;
  vec_t nxt;
  logic go, last, mism;
  // Outside a run the ROM is addressed at 0 so a start loads vector 0.
  assign idx_n = busy ? idx + 1'b1 : '0;
  assign go = (state == S_IDLE || state == S_DONE) && start;
  assign last = idx == IW'(NUM_VEC - 1);
  assign mism = dut_out != exp_ct;
  aes_bist_vec_rom #(.NUM_VEC(NUM_VEC)) u_rom (.idx(idx_n), .vec(nxt));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: state_n = start ? S_RST_DUT : state;
      S_RST_DUT:      state_n = cnt == CW'(RST_CYC - 1) ? S_WAIT : state;
      S_WAIT:         state_n = cnt == CW'(LATENCY - 1) ? S_CHECK : state;
      S_CHECK:        state_n = last ? S_DONE : S_RST_DUT;
      default:        state_n = S_IDLE;
    endcase
    busy = state == S_RST_DUT || state == S_WAIT || state == S_CHECK;
    dut_rst = !(state == S_WAIT || state == S_CHECK);
    done = state == S_DONE;
    pass = done && fail_count == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      plaintext <= '0;
      key <= '0;
      exp_ct <= '0;
      fail_count <= '0;
      first_fail_idx <= '1;
`ifdef AES_BIST_CAPTURE_EN
      fail_capture <= '0;
`endif
    end else begin
      // Counts cycles spent in the current state.
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      if (go) begin
        idx <= '0;
        plaintext <= nxt.pt[DATA_W-1:0];
        key <= nxt.key[DATA_W-1:0];
        exp_ct <= nxt.ct[DATA_W-1:0];
        fail_count <= '0;
        first_fail_idx <= '1;
`ifdef AES_BIST_CAPTURE_EN
        fail_capture <= '0;
`endif
      end else if (state == S_CHECK) begin
        if (mism) begin
          if (fail_count != FW'(NUM_VEC)) fail_count <= fail_count + 1'b1;
          if (fail_count == '0) begin
            first_fail_idx <= idx;
`ifdef AES_BIST_CAPTURE_EN
            fail_capture <= dut_out ^ exp_ct;
`endif
          end
        end
        if (!last) begin
          idx <= idx_n;
          plaintext <= nxt.pt[DATA_W-1:0];
          key <= nxt.key[DATA_W-1:0];
          exp_ct <= nxt.ct[DATA_W-1:0];
        end
      end
    end
endmodule

// File: tb/tb_aes_bist_sequencer.sv
// tb_aes_bist_sequencer: randomized self-checking bench with behavioural AES stub and result model
module tb_aes_bist_sequencer;
  localparam int NV = 4, RC = 2, LAT = 5, P = RC + LAT + 1;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  logic clk = 0, rst = 0, start = 0, start2 = 0;
  logic dut_rst, busy, done, pass, dut_rst2, busy2, done2, pass2;
  logic [127:0] pt, key, dut_out, exp_ct, pt2, key2, dut_out2, cap, cap2, flip2;
  logic [2:0] fc;
  logic [1:0] ffi;
  logic [0:0] fc2, ffi2;
  logic [127:0] flip [NV];
  int lowcnt = 0, vnum = 0, ready_d = LAT;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  aes_bist_sequencer #(.NUM_VEC(NV), .LATENCY(LAT), .RST_CYC(RC), .DATA_W(128)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst), .plaintext(pt), .key(key),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .fail_count(fc),
`ifdef AES_BIST_CAPTURE_EN
    .fail_capture(cap),
`endif
    .first_fail_idx(ffi));
  aes_bist_sequencer #(.NUM_VEC(1), .LATENCY(1), .RST_CYC(1), .DATA_W(128)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dut_rst(dut_rst2), .plaintext(pt2), .key(key2),
    .dut_out(dut_out2), .busy(busy2), .done(done2), .pass(pass2), .fail_count(fc2),
`ifdef AES_BIST_CAPTURE_EN
    .fail_capture(cap2),
`endif
    .first_fail_idx(ffi2));
`ifndef AES_BIST_CAPTURE_EN
  assign cap = '0;
  assign cap2 = '0;
`endif
  // AES stub: lowcnt = edges seen out of reset, vnum = vector number within the run.
  always @(posedge clk)
    if (!busy) begin
      lowcnt <= 0;
      vnum <= 0;
    end else if (!dut_rst) lowcnt <= lowcnt + 1;
    else begin
      if (lowcnt != 0) vnum <= vnum + 1;
      lowcnt <= 0;
    end
  always_comb begin
    exp_ct = (pt == P0 && key == K0) ? C0 : (pt == P1 && key == K1) ? C1 : '0;
    dut_out = lowcnt >= ready_d ? exp_ct ^ flip[vnum % NV] : ~exp_ct;
    dut_out2 = ((pt2 == P0 && key2 == K0) ? C0 : '0) ^ flip2;
  end
  task automatic model(output int fails, output int fi, output logic [127:0] ce);
    fails = 0;
    fi = 3;
    ce = '0;
    for (int v = 0; v < NV; v++) begin
      logic [127:0] d;
      d = ready_d > LAT ? '1 : flip[v];
      if (d != '0) begin
        if (fails == 0) begin
          fi = v;
          ce = d;
        end
        fails++;
      end
    end
  endtask
  task automatic run(output int cyc);
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask
  task automatic check_run(input string name, input int cyc);
    int fails, fi;
    logic [127:0] ce;
    model(fails, fi, ce);
    n_checks++;
    if (cyc !== NV * P) begin
      n_fail++;
      $display("FAIL %s run length: got %0d cycles, want %0d", name, cyc, NV * P);
    end
    n_checks++;
    if ({pass, fc, ffi} !== {fails == 0, 3'(fails), 2'(fi)}) begin
      n_fail++;
      $display("FAIL %s results: got pass=%0b fc=%0d ffi=%0d, want pass=%0b fc=%0d ffi=%0d",
               name, pass, fc, ffi, fails == 0, fails, 2'(fi));
    end
`ifdef AES_BIST_CAPTURE_EN
    n_checks++;
    if (cap !== ce) begin
      n_fail++;
      $display("FAIL %s capture: got %h, want %h", name, cap, ce);
    end
`endif
  endtask
  task automatic test_reset;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({dut_rst, busy, done, pass, fc, ffi, pt, key, cap} !== {4'b1000, 3'd0, 2'b11, 384'd0}) begin
      n_fail++;
      $display("FAIL reset main: got rst=%b busy=%b done=%b pass=%b fc=%0d ffi=%b pt=%h key=%h", dut_rst, busy, done, pass, fc, ffi, pt, key);
    end
    n_checks++;
    if ({dut_rst2, busy2, done2, pass2, fc2, ffi2, pt2, key2} !== {4'b1000, 1'b0, 1'b1, 256'd0}) begin
      n_fail++;
      $display("FAIL reset small: got rst=%b busy=%b done=%b pass=%b fc=%0d ffi=%b", dut_rst2, busy2, done2, pass2, fc2, ffi2);
    end
    @(negedge clk) rst = 0;
    repeat (2) @(posedge clk);
  endtask
  task automatic test_golden;
    int cyc;
    foreach (flip[v]) flip[v] = '0;
    ready_d = LAT;
    run(cyc);
    check_run("golden", cyc);
    n_checks++;
    if (dut_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL golden parked: dut_rst=%b, want 1", dut_rst);
    end
  endtask
  task automatic test_random_flips;
    int cyc, r;
    for (int it = 0; it < 6; it++) begin
      foreach (flip[v]) begin
        r = $urandom_range(0, 3);
        flip[v] = r == 0 ? 128'd1 << $urandom_range(0, 127) : r == 1 ? {4{$urandom()}} : '0;
      end
      if (it == 0) foreach (flip[v]) flip[v] = v == 1 ? 128'd1 : '0;
      ready_d = LAT - $urandom_range(0, 2);
      run(cyc);
      check_run("random_flips", cyc);
    end
  endtask
  task automatic test_latency;
    int cyc;
    foreach (flip[v]) flip[v] = '0;
    ready_d = LAT + 1;
    run(cyc);
    check_run("late_core", cyc);
    ready_d = LAT;
    run(cyc);
    check_run("late_core_fixed", cyc);
  endtask
  task automatic test_stimulus_stable;
    logic [127:0] ep, ek;
    int v;
    foreach (flip[i]) flip[i] = '0;
    ready_d = LAT;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int k = 1; k <= NV * P; k++) begin
      v = (k - 1) / P;
      ep = v % 2 ? P1 : P0;
      ek = v % 2 ? K1 : K0;
      n_checks++;
      if ({pt, key, dut_rst, busy} !== {ep, ek, (k - 1) % P < RC, 1'b1}) begin
        n_fail++;
        $display("FAIL stimulus cycle %0d: got pt=%h rst=%b busy=%b, want pt=%h rst=%b", k, pt, dut_rst, busy, ep, (k - 1) % P < RC);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if ({done, busy, pass} !== 3'b101) begin
      n_fail++;
      $display("FAIL stimulus end: got done=%b busy=%b pass=%b, want 1 0 1", done, busy, pass);
    end
  endtask
  task automatic test_back_to_back;
    int cyc;
    foreach (flip[v]) flip[v] = v == 2 ? 128'h80 : '0;
    ready_d = LAT;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (cyc == RC + 2) start = 1;
      if (cyc == RC + 3) start = 0;
      @(posedge clk);
      #1 cyc++;
    end
    start = 0;
    check_run("start_ignored", cyc);
    foreach (flip[v]) flip[v] = '0;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    n_checks++;
    if ({busy, done, pass, fc, ffi} !== {3'b100, 3'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL restart clear: got busy=%b done=%b pass=%b fc=%0d ffi=%b, want 1 0 0 0 11", busy, done, pass, fc, ffi);
    end
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
    end
    check_run("restart", cyc);
  endtask
  task automatic test_rst_mid;
    foreach (flip[v]) flip[v] = v == 0 ? 128'h5 : '0;
    ready_d = LAT;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (P + RC + 2) @(posedge clk);
    #1 rst = 1;
    #1;
    n_checks++;
    if ({dut_rst, busy, done, pass, fc, ffi, pt, key, cap} !== {4'b1000, 3'd0, 2'b11, 384'd0}) begin
      n_fail++;
      $display("FAIL rst_mid: got rst=%b busy=%b done=%b pass=%b fc=%0d ffi=%b pt=%h", dut_rst, busy, done, pass, fc, ffi, pt);
    end
    @(negedge clk) rst = 0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, dut_rst} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_mid release: got busy=%b done=%b dut_rst=%b, want 0 0 1", busy, done, dut_rst);
    end
  endtask
  task automatic test_small;
    int cyc;
    for (int it = 0; it < 2; it++) begin
      flip2 = it == 0 ? '0 : 128'd1 << $urandom_range(0, 127);
      @(negedge clk) start2 = 1;
      @(posedge clk);
      #1 start2 = 0;
      cyc = 0;
      while (!done2 && cyc < 200) begin
        @(posedge clk);
        #1 cyc++;
      end
      n_checks++;
      if (cyc !== 3) begin
        n_fail++;
        $display("FAIL small run length: got %0d, want 3", cyc);
      end
      n_checks++;
      if ({pass2, fc2, ffi2} !== (it == 0 ? 3'b101 : 3'b010)) begin
        n_fail++;
        $display("FAIL small results: got pass=%b fc=%0d ffi=%b (iteration %0d)", pass2, fc2, ffi2, it);
      end
`ifdef AES_BIST_CAPTURE_EN
      n_checks++;
      if (cap2 !== flip2) begin
        n_fail++;
        $display("FAIL small capture: got %h, want %h", cap2, flip2);
      end
`endif
    end
  endtask
  initial begin
    flip2 = '0;
    foreach (flip[v]) flip[v] = '0;
    test_reset();
    test_golden();
    test_random_flips();
    test_latency();
    test_stimulus_stable();
    test_back_to_back();
    test_rst_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
